// File: rtl/spi_ram_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : spi_ram_ctrl_if
// Brief  : Frame input, read-data handshake and error flags of spi_ram_ctrl.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface spi_ram_ctrl_if #(
    parameter int WORD_SIZE = 8
);
    logic                   rx_valid;
    logic [WORD_SIZE+1:0]   din;
    logic                   tx_ready;
    logic                   err_clr;
    logic                   tx_valid;
    logic [WORD_SIZE-1:0]   dout;
    logic                   ovf;
    logic                   oor;

    modport master (
        output rx_valid, din, tx_ready, err_clr,
        input  tx_valid, dout, ovf, oor
    );

    modport slave (
        input  rx_valid, din, tx_ready, err_clr,
        output tx_valid, dout, ovf, oor
    );
endinterface
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : spi_ram_ctrl
// Brief  : Command-driven RAM behind an SPI slave; read data via valid/ready.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_ctrl_if.slave   bus
);
    localparam logic [1:0] c_set_waddr = 2'b00;
    localparam logic [1:0] c_write     = 2'b01;
    localparam logic [1:0] c_set_raddr = 2'b10;
    localparam logic [1:0] c_read      = 2'b11;

    logic [WORD_SIZE-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_tx_valid;
    logic [WORD_SIZE-1:0] r_dout;
    logic                 r_ovf;
    logic                 r_oor;

    logic [1:0]           w_cmd;
    logic [WORD_SIZE-1:0] w_payload;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_wr_in;
    logic                 w_rd_in;
    logic                 w_is_write;
    logic                 w_is_read;
    logic                 w_slot_free;
    logic                 w_rd_acc;
    logic                 w_rd_drop;
    logic                 w_oor_evt;

    // Wrap at the last real word; pointers already past the array just roll over.
    function automatic logic [ADDR_SIZE-1:0] f_inc(input logic [ADDR_SIZE-1:0] p);
        if (32'(p) == MEM_DEPTH - 1) return '0;
        return p + ADDR_SIZE'(1);
    endfunction

    assign w_cmd       = bus.din[WORD_SIZE+1:WORD_SIZE];
    assign w_payload   = bus.din[WORD_SIZE-1:0];
    assign w_addr      = w_payload[ADDR_SIZE-1:0];
    assign w_wr_in     = 32'(r_wr_addr) < MEM_DEPTH;
    assign w_rd_in     = 32'(r_rd_addr) < MEM_DEPTH;
    assign w_is_write  = bus.rx_valid && (w_cmd == c_write);
    assign w_is_read   = bus.rx_valid && (w_cmd == c_read);
    assign w_slot_free = !r_tx_valid || bus.tx_ready;
    assign w_rd_acc    = w_is_read && w_slot_free;
    assign w_rd_drop   = w_is_read && !w_slot_free;
    assign w_oor_evt   = (w_is_write && !w_wr_in) || (w_rd_acc && !w_rd_in);

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && w_is_write && w_wr_in) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_tx_valid <= 1'b0;
            r_dout     <= '0;
            r_ovf      <= 1'b0;
            r_oor      <= 1'b0;
        end else begin
            if (bus.rx_valid) begin
                case (w_cmd)
                    c_set_waddr: r_wr_addr <= w_addr;
                    c_write:     if (AUTO_INC != 0) r_wr_addr <= f_inc(r_wr_addr);
                    c_set_raddr: r_rd_addr <= w_addr;
                    default:     if (w_slot_free && AUTO_INC != 0) r_rd_addr <= f_inc(r_rd_addr);
                endcase
            end

            // An accepted read refills the slot in the same cycle it drains.
            if (w_rd_acc) begin
                r_tx_valid <= 1'b1;
                r_dout     <= w_rd_in ? r_mem[r_rd_addr] : '0;
            end else if (r_tx_valid && bus.tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            r_ovf <= w_rd_drop || (r_ovf && !bus.err_clr);
            r_oor <= w_oor_evt || (r_oor && !bus.err_clr);
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.dout     = r_dout;
    assign bus.ovf      = r_ovf;
    assign bus.oor      = r_oor;
endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_spi_ram_ctrl
// Brief  : Scoreboard bench over three spi_ram_ctrl configurations.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_spi_ram_ctrl;
    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [9:0] din;
    logic       tx_ready;
    logic       err_clr;
    int         sel;

    logic       tx_valid_m;
    logic [7:0] dout_m;
    logic       ovf_m;
    logic       oor_m;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    spi_ram_ctrl_if #(.WORD_SIZE(8)) b0 ();
    spi_ram_ctrl_if #(.WORD_SIZE(8)) b1 ();
    spi_ram_ctrl_if #(.WORD_SIZE(8)) b2 ();

    // 0: defaults, 1: non-power-of-two depth, 2: static pointers
    spi_ram_ctrl #(.WORD_SIZE(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1))
        u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    spi_ram_ctrl #(.WORD_SIZE(8), .ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    spi_ram_ctrl #(.WORD_SIZE(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(0))
        u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    assign b0.rx_valid = rx_valid && (sel == 0);
    assign b1.rx_valid = rx_valid && (sel == 1);
    assign b2.rx_valid = rx_valid && (sel == 2);
    assign b0.din = din;       assign b1.din = din;       assign b2.din = din;
    assign b0.tx_ready = tx_ready; assign b1.tx_ready = tx_ready; assign b2.tx_ready = tx_ready;
    assign b0.err_clr = err_clr;   assign b1.err_clr = err_clr;   assign b2.err_clr = err_clr;

    assign tx_valid_m = (sel == 0) ? b0.tx_valid : (sel == 1) ? b1.tx_valid : b2.tx_valid;
    assign dout_m     = (sel == 0) ? b0.dout     : (sel == 1) ? b1.dout     : b2.dout;
    assign ovf_m      = (sel == 0) ? b0.ovf      : (sel == 1) ? b1.ovf      : b2.ovf;
    assign oor_m      = (sel == 0) ? b0.oor      : (sel == 1) ? b1.oor      : b2.oor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p);
        rx_valid = 1'b1;
        din      = {c, p};
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    // Monitor: every completed transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && tx_valid_m && tx_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got dout=%0h, required no transfer", dout_m);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout_m !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_data: got dout=%0h, required %0h", dout_m, mon_exp);
                end
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        sel      = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = '0;
        tx_ready = 1'b0;
        err_clr  = 1'b0;
        idle(2);
        rst = 1'b0;
        check("rst_tx_valid", 32'(tx_valid_m), 0);
        check("rst_dout",     32'(dout_m),     0);
        check("rst_ovf",      32'(ovf_m),      0);
        check("rst_oor",      32'(oor_m),      0);

        // Burst write then back-to-back reads
        tx_ready = 1'b1;
        send(2'b00, 8'h10);
        send(2'b01, 8'hA1);
        send(2'b01, 8'hA2);
        send(2'b01, 8'hA3);
        send(2'b10, 8'h10);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        send(2'b11, 8'h00);
        check("burst_valid1", 32'(tx_valid_m), 1);
        send(2'b11, 8'h00);
        check("burst_valid2", 32'(tx_valid_m), 1);
        send(2'b11, 8'h00);
        check("burst_valid3", 32'(tx_valid_m), 1);
        check("burst_ovf",    32'(ovf_m),      0);
        idle(1);
        check("burst_drain",  32'(tx_valid_m), 0);

        // Backpressure and overrun
        send(2'b10, 8'h10);
        tx_ready = 1'b0;
        exp_q.push_back(8'hA1);
        send(2'b11, 8'h00);
        check("bp_valid", 32'(tx_valid_m), 1);
        check("bp_ovf0",  32'(ovf_m),      0);
        send(2'b11, 8'h00);
        check("bp_ovf1",  32'(ovf_m),      1);
        check("bp_hold",  32'(dout_m),     32'h A1);
        tx_ready = 1'b1;
        idle(1);
        check("bp_drop_valid", 32'(tx_valid_m), 0);
        exp_q.push_back(8'hA2);
        send(2'b11, 8'h00);
        idle(1);
        pulse_clr();
        check("bp_clr", 32'(ovf_m), 0);

        // Overrun in the same cycle as clear: set wins
        tx_ready = 1'b0;
        exp_q.push_back(8'hA3);
        send(2'b11, 8'h00);
        err_clr = 1'b1;
        send(2'b11, 8'h00);
        err_clr = 1'b0;
        check("clr_set_wins", 32'(ovf_m), 1);
        tx_ready = 1'b1;
        idle(2);
        pulse_clr();

        // Pointer wrap at the top of a 256-word array
        send(2'b00, 8'hFF);
        send(2'b01, 8'h55);
        send(2'b01, 8'h66);
        send(2'b10, 8'hFF);
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        idle(1);
        check("wrap_oor", 32'(oor_m), 0);

        // Reset with a word pending
        tx_ready = 1'b0;
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        check("pre_rst_ovf", 32'(ovf_m), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_valid", 32'(tx_valid_m), 0);
        check("mid_rst_dout",  32'(dout_m),     0);
        check("mid_rst_ovf",   32'(ovf_m),      0);
        check("mid_rst_oor",   32'(oor_m),      0);
        tx_ready = 1'b1;
        exp_q.push_back(8'h66);
        send(2'b11, 8'h00);
        send(2'b01, 8'h99);
        send(2'b10, 8'h00);
        exp_q.push_back(8'h99);
        send(2'b11, 8'h00);
        send(2'b10, 8'h10);
        exp_q.push_back(8'hA1);
        send(2'b11, 8'h00);
        idle(1);

        // Out of range with MEM_DEPTH=200
        sel = 1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(2'b00, 8'hC8);
        send(2'b01, 8'h77);
        check("oor_write", 32'(oor_m), 1);
        pulse_clr();
        check("oor_clr", 32'(oor_m), 0);
        send(2'b00, 8'hC7);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        check("oor_last_word", 32'(oor_m), 0);
        send(2'b10, 8'hC7);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        send(2'b10, 8'hC8);
        exp_q.push_back(8'h00);
        send(2'b11, 8'h00);
        check("oor_read_valid", 32'(tx_valid_m), 1);
        idle(1);
        check("oor_read_flag", 32'(oor_m), 1);

        // Static pointers
        sel = 2;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(2'b00, 8'h05);
        send(2'b01, 8'h5A);
        send(2'b01, 8'h3C);
        send(2'b10, 8'h05);
        exp_q.push_back(8'h3C); exp_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Parametrised command-driven RAM that sits behind the SPI slave shift logic. It decodes the 2-bit command field of each received frame and keeps independent write and read address pointers, with optional auto-increment for burst transfers. Read data is returned over a valid/ready handshake with backpressure, and overrun and range errors are reported through sticky flags.

Parameters:
WORD_SIZE, 8, data word width in bits; din is WORD_SIZE+2 wide.
ADDR_SIZE, 8, address pointer width; must be <= WORD_SIZE.
MEM_DEPTH, 256, number of words; must be <= 2**ADDR_SIZE (non-power-of-two allowed).
AUTO_INC, 1, 1 = pointer post-increments after each WRITE/READ; 0 = pointers static.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous active-high reset.
rx_valid  in  1  din holds a complete frame this cycle.
din  in  WORD_SIZE+2  [WORD_SIZE+1:WORD_SIZE] = command, [WORD_SIZE-1:0] = payload.
tx_ready  in  1  consumer accepts dout this cycle.
err_clr  in  1  clears the sticky error flags.
tx_valid  out  1  dout holds unconsumed read data.
dout  out  WORD_SIZE  read data.
ovf  out  1  sticky: a READ was dropped because the tx slot was busy.
oor  out  1  sticky: an access was made at address >= MEM_DEPTH.

Behaviour:
- Reset (rst=1 at posedge):
  - tx_valid=0, dout=0, wr_addr=0, rd_addr=0, ovf=0, oor=0.
  - mem contents not reset.
  - Reset overrides every other input that cycle, including a pending tx.
- Commands are decoded only when rx_valid=1. The address field is payload[ADDR_SIZE-1:0].
  - 00 SET_WADDR: wr_addr <= address field.
  - 01 WRITE: if wr_addr < MEM_DEPTH, mem[wr_addr] <= payload. Otherwise no write and oor <= 1. If AUTO_INC, wr_addr advances either way.
  - 10 SET_RADDR: rd_addr <= address field.
  - 11 READ: accepted when the tx slot is free, i.e. tx_valid=0, or tx_valid=1 and tx_ready=1 in the same cycle.
    - On accept: dout <= mem[rd_addr], or 0 with oor <= 1 if rd_addr >= MEM_DEPTH. tx_valid <= 1. If AUTO_INC, rd_addr advances.
    - If the slot is not free: command dropped, ovf <= 1, rd_addr and dout unchanged.
- Pointer increment: MEM_DEPTH-1 -> 0 (wrap). A pointer that is already >= MEM_DEPTH increments modulo 2**ADDR_SIZE.
- Latency: READ accepted at edge N -> tx_valid=1 and dout valid after edge N (visible in cycle N+1).
- TX handshake:
  - Transfer occurs when tx_valid & tx_ready.
  - Transfer with no accepted READ that cycle -> tx_valid <= 0, dout holds its last value.
  - Transfer together with an accepted READ -> tx_valid stays 1 and dout is updated (back-to-back, no bubble).
  - While tx_valid=1 and tx_ready=0, dout must be stable.
- Non-READ commands never alter tx_valid or dout.
- Write-then-read ordering: a WRITE at edge N is visible to a READ of the same address at edge N+1 or later. Only one command is possible per cycle.
- Error flags:
  - err_clr=1 clears ovf and oor.
  - If a new error occurs in the same cycle as err_clr, the set wins (flag = 1).
- Sequential only: mem is a synchronous-write array with a registered read path, inferable as block RAM.

Test Plan:
- Reset then burst write (AUTO_INC=1): SET_WADDR 0x10, WRITE 0xA1, 0xA2, 0xA3; SET_RADDR 0x10; three READs with tx_ready=1 -> dout 0xA1, 0xA2, 0xA3 on consecutive cycles, tx_valid continuously 1, ovf=0.
- Backpressure: READ with tx_ready=0, then a second READ while tx_valid=1 -> ovf=1, dout holds the first word, rd_addr advanced by 1 only. Raise tx_ready -> tx_valid drops next cycle. err_clr -> ovf=0.
- Wrap: MEM_DEPTH=256, SET_WADDR 0xFF, WRITE 0x55, WRITE 0x66 -> mem[0xFF]=0x55, mem[0x00]=0x66. Read back via SET_RADDR 0xFF and two READs -> 0x55, 0x66.
- Out of range: MEM_DEPTH=200, SET_WADDR 0xC8, WRITE 0x77 -> no array write, oor=1. SET_RADDR 0xC8, READ -> dout=0x00, tx_valid=1.
- AUTO_INC=0: SET_RADDR 0x05 (mem[5]=0x3C), three READs with tx_ready=1 -> dout 0x3C three times, rd_addr remains 0x05.
- Reset mid-operation: tx_valid=1 with tx_ready=0, assert rst for one cycle -> tx_valid=0, dout=0, ovf=oor=0, pointers 0. mem[0x10] written earlier still reads 0xA1.
